fetch_stage: RTL and testbench

- Instruction fetch stage that feeds the decode stage. Supplies insn, pc and valid_insn.
- Holds the fetch PC and issues word requests to instruction memory over a request/grant plus in-order response handshake.
- Buffers returned words in a small FIFO so that decode back-pressure (stall) does not lose data.
- On a branch or jump redirect, flushes buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding decode. Holds the fetch PC, issues word
//   requests to instruction memory (request/grant, in-order responses), and
//   buffers returned words in a small pc/insn FIFO so decode stalls lose
//   nothing. A redirect flushes the FIFO and turns every in-flight request
//   into a stale one whose response is discarded on arrival.
//
//   Optional build macro: FETCH_ALIGN_CHECK_EN
//     defined   : a misaligned redirect sets sticky fetch_err and parks the
//                 stage in HALT until reset.
//     undefined : fetch_err is tied 0 and redirect targets are word-aligned.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   stall                   decode cannot accept; FIFO head is held
//   redirect, redirect_pc   one-cycle branch/jump redirect and its target
//   imem_req, imem_addr     fetch request and word address (= fetch PC)
//   imem_gnt                request accepted this cycle
//   imem_rvalid, imem_rdata in-order response, one per grant
//   insn, pc, valid_insn    FIFO head to decode
//   fetch_err               sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] insn,
   output logic [31:0] pc,
   output logic        valid_insn,
   output logic        fetch_err
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_HALT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;
`endif

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d;
   logic [PTR_W-1:0] fifo_rd_ptr_q, fifo_rd_ptr_d;
   logic [PTR_W-1:0] iss_wr_ptr_q, iss_wr_ptr_d;
   logic [PTR_W-1:0] iss_rd_ptr_q, iss_rd_ptr_d;
   logic             fetch_err_q, fetch_err_d;

   logic [31:0] fifo_pc_q   [FIFO_DEPTH];
   logic [31:0] fifo_insn_q [FIFO_DEPTH];
   logic [31:0] iss_pc_q    [FIFO_DEPTH];   // PCs of live (non-stale) requests

   logic             fifo_push, iss_push;
   logic             resp_ok, grant, pop, halted;
   logic [CNT_W-1:0] resp_dec;
   logic [CNT_W:0]   credit_used;
   logic [31:0]      target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   assign halted    = (state_q == ST_HALT);
   assign target_pc = redirect_pc;
`else
   logic unused_low_bits;
   assign unused_low_bits = ^redirect_pc[1:0];
   assign halted    = 1'b0;
   assign target_pc = {redirect_pc[31:2], 2'b00};
`endif

   // Every slot in the FIFO is backed by a credit: a request is only made
   // while outstanding + buffered leaves room, so a push never overflows.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
   assign imem_req    = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !redirect
                        && (credit_used < DEPTH_C);
   assign imem_addr   = fetch_pc_q;
   assign grant       = imem_req && imem_gnt;
   assign valid_insn  = (fifo_cnt_q != '0);
   assign pop         = valid_insn && !stall;
   assign insn        = fifo_insn_q[fifo_rd_ptr_q];
   assign pc          = fifo_pc_q[fifo_rd_ptr_q];
   assign fetch_err   = fetch_err_q;
   assign resp_ok     = imem_rvalid && (outstanding_q != '0);
   assign resp_dec    = resp_ok ? CNT_ONE : '0;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      fifo_cnt_d    = fifo_cnt_q;
      fifo_wr_ptr_d = fifo_wr_ptr_q;
      fifo_rd_ptr_d = fifo_rd_ptr_q;
      iss_wr_ptr_d  = iss_wr_ptr_q;
      iss_rd_ptr_d  = iss_rd_ptr_q;
      fetch_err_d   = fetch_err_q;
      fifo_push     = 1'b0;
      iss_push      = 1'b0;

      if (halted) begin
         // Parked: only retire whatever was still in flight, and discard it.
         outstanding_d = outstanding_q - resp_dec;
         if (resp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else if (redirect) begin
         // All in-flight requests become stale; a response arriving right
         // now is one of them and retires immediately.
         fifo_cnt_d    = '0;
         fifo_wr_ptr_d = '0;
         fifo_rd_ptr_d = '0;
         iss_wr_ptr_d  = '0;
         iss_rd_ptr_d  = '0;
         outstanding_d = outstanding_q - resp_dec;
         drop_cnt_d    = outstanding_q - resp_dec;
         fetch_pc_d    = target_pc;
         state_d       = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
            state_d     = ST_HALT;
         end
`endif
      end else begin
         if (resp_ok) begin
            outstanding_d = outstanding_q - CNT_ONE;
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
               fifo_push    = 1'b1;
               iss_rd_ptr_d = iss_rd_ptr_q + PTR_ONE;
            end
         end
         if (grant) begin
            iss_push      = 1'b1;
            iss_wr_ptr_d  = iss_wr_ptr_q + PTR_ONE;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            outstanding_d = outstanding_d + CNT_ONE;
         end
         if (fifo_push) fifo_wr_ptr_d = fifo_wr_ptr_q + PTR_ONE;
         if (pop)       fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_ONE;
         fifo_cnt_d = fifo_cnt_q + (fifo_push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
         state_d    = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         fifo_cnt_q    <= '0;
         fifo_wr_ptr_q <= '0;
         fifo_rd_ptr_q <= '0;
         iss_wr_ptr_q  <= '0;
         iss_rd_ptr_q  <= '0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         fifo_cnt_q    <= fifo_cnt_d;
         fifo_wr_ptr_q <= fifo_wr_ptr_d;
         fifo_rd_ptr_q <= fifo_rd_ptr_d;
         iss_wr_ptr_q  <= iss_wr_ptr_d;
         iss_rd_ptr_q  <= iss_rd_ptr_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   // Storage entries; reset to zero so insn/pc read 0 out of reset.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            fifo_pc_q[gi]   <= '0;
            fifo_insn_q[gi] <= '0;
            iss_pc_q[gi]    <= '0;
         end else begin
            if (fifo_push && (fifo_wr_ptr_q == PTR_W'(gi))) begin
               fifo_pc_q[gi]   <= iss_pc_q[iss_rd_ptr_q];
               fifo_insn_q[gi] <= imem_rdata;
            end
            if (iss_push && (iss_wr_ptr_q == PTR_W'(gi))) begin
               iss_pc_q[gi] <= fetch_pc_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] insn, pc;
   logic        valid_insn, fetch_err;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .insn(insn), .pc(pc), .valid_insn(valid_insn), .fetch_err(fetch_err));

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- reference model (queues) ----------------
   typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
   ent_t        m_fifo[$];     // words waiting for decode
   logic [31:0] m_issued[$];   // PCs of live requests still in flight
   logic [31:0] mem_q[$];      // addresses the memory owes a response for
   int          m_drop;        // stale responses still to come
   bit          m_idle, m_halt, m_err;
   logic [31:0] m_fetch_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete(); m_issued.delete(); mem_q.delete();
      m_drop = 0; m_idle = 1; m_halt = 0; m_err = 0; m_fetch_pc = RST_PC;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      check1("rst req", imem_req, 1'b0);
      check1("rst valid", valid_insn, 1'b0);
      check32("rst insn", insn, 32'h0);
      check32("rst pc", pc, 32'h0);
      check1("rst err", fetch_err, 1'b0);
      check32("rst addr", imem_addr, RST_PC);
      rst_n = 1'b1;
      model_reset();
      $display("reset released");
   endtask

   // One clock: drive inputs, compare DUT with the model, advance both.
   task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                       input bit gn, input bit rv_try);
      bit          exp_req, rv, resp, pop;
      int          o;
      logic [31:0] rdata;
      ent_t        e;
      rv    = rv_try;
      rdata = (rv && mem_q.size() > 0) ? mem_word(mem_q[0]) : $urandom;
      stall = st; redirect = rd; redirect_pc = rpc; imem_gnt = gn;
      imem_rvalid = rv; imem_rdata = rdata;
      #1;
      o       = m_drop + m_issued.size();
      exp_req = !m_idle && !m_halt && !rd && (o + m_fifo.size() < DEPTH);
      check1("req", imem_req, exp_req);
      check32("addr", imem_addr, m_fetch_pc);
      check1("valid", valid_insn, m_fifo.size() > 0);
      check1("err", fetch_err, m_err);
      if (m_fifo.size() > 0) begin
         check32("pc", pc, m_fifo[0].pc);
         check32("insn", insn, m_fifo[0].insn);
      end
      $display("cyc st=%0b rd=%0b gnt=%0b rv=%0b | req=%0b addr=%h valid=%0b pc=%h insn=%h",
               st, rd, gn, rv, imem_req, imem_addr, valid_insn, pc, insn);
      @(posedge clk);
      resp = rv && (o > 0);
      // memory side
      if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
      if (exp_req && gn) mem_q.push_back(m_fetch_pc);
      // stage side
      if (m_idle) begin
         m_idle = 0;
      end else if (m_halt) begin
         if (resp) m_drop--;
      end else if (rd) begin
         m_fifo.delete();
         m_drop = o - (resp ? 1 : 0);
         m_issued.delete();
`ifdef FETCH_ALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) begin m_err = 1; m_halt = 1; end
         m_fetch_pc = rpc;
`else
         m_fetch_pc = rpc & 32'hFFFF_FFFC;
`endif
      end else begin
         pop = (m_fifo.size() > 0) && !st;
         if (pop) void'(m_fifo.pop_front());
         if (resp) begin
            if (m_drop > 0) m_drop--;
            else begin
               e.pc = m_issued.pop_front();
               e.insn = rdata;
               m_fifo.push_back(e);
            end
         end
         if (exp_req && gn) begin
            m_issued.push_back(m_fetch_pc);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   // Steps with an always-granting, 1-cycle memory until a valid word shows.
   task automatic first_valid_pc(input string name, input logic [31:0] exp_pc);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (valid_insn) begin
            seen = 1;
            check32(name, pc, exp_pc);
         end else step(0, 0, 32'h0, 1, 1);
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL %s: no valid_insn within 20 cycles, expected pc %h", name, exp_pc);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit rv; logic [31:0] rd_addr;
      bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
   } vec_t;
   vec_t tbl[8];

   initial begin
      bit          st, rd, gn, rv;
      logic [31:0] rpc;

      // Memory always grants and answers one cycle later; credit limit 2.
      tbl[0] = '{0, 32'h0,        0, 32'h0040_0000, 0, 32'h0};
      tbl[1] = '{0, 32'h0,        1, 32'h0040_0000, 0, 32'h0};
      tbl[2] = '{1, 32'h0040_0000, 1, 32'h0040_0004, 0, 32'h0};
      tbl[3] = '{1, 32'h0040_0004, 0, 32'h0040_0008, 1, 32'h0040_0000};
      tbl[4] = '{0, 32'h0,        1, 32'h0040_0008, 1, 32'h0040_0004};
      tbl[5] = '{1, 32'h0040_0008, 1, 32'h0040_000C, 0, 32'h0};
      tbl[6] = '{1, 32'h0040_000C, 0, 32'h0040_0010, 1, 32'h0040_0008};
      tbl[7] = '{0, 32'h0,        1, 32'h0040_0010, 1, 32'h0040_000C};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         stall = 0; redirect = 0; imem_gnt = 1;
         imem_rvalid = tbl[i].rv;
         imem_rdata  = tbl[i].rv ? mem_word(tbl[i].rd_addr) : 32'h0;
         #1;
         check1($sformatf("tbl%0d req", i), imem_req, tbl[i].e_req);
         check32($sformatf("tbl%0d addr", i), imem_addr, tbl[i].e_addr);
         check1($sformatf("tbl%0d valid", i), valid_insn, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            check32($sformatf("tbl%0d pc", i), pc, tbl[i].e_pc);
            check32($sformatf("tbl%0d insn", i), insn, mem_word(tbl[i].e_pc));
         end
         $display("tbl%0d req=%0b addr=%h valid=%0b pc=%h", i, imem_req, imem_addr, valid_insn, pc);
         @(posedge clk);
         @(negedge clk);
      end

      // Stall held after the first valid word: credits run out, head holds.
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1);
      for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 1);
      check1("stall req", imem_req, 1'b0);
      check32("stall pc", pc, 32'h0040_0000);
      for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 1, 1);

      // Redirect with two requests in flight: both stale words are dropped.
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0);
      step(0, 1, 32'h0040_0100, 1, 0);
      first_valid_pc("redir2 first pc", 32'h0040_0100);
      for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 1);

      // Redirect in the same cycle as a response and a FIFO pop.
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1);
      step(0, 1, 32'h0040_0200, 1, 1);
      check1("coinc valid", valid_insn, 1'b0);
      first_valid_pc("coinc first pc", 32'h0040_0200);

      // Fetch PC wraps past the top of the address space.
      do_reset();
      step(0, 0, 32'h0, 1, 1);
      step(0, 1, 32'hFFFF_FFF8, 1, 1);
      step(0, 0, 32'h0, 1, 1);
      step(0, 0, 32'h0, 1, 1);
      check32("wrap addr", imem_addr, 32'h0000_0000);
      for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 1, 1);

`ifdef FETCH_ALIGN_CHECK_EN
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 1);
      step(0, 1, 32'h0040_0102, 1, 1);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 32'h0, 1, 1);
         check1("halt err", fetch_err, 1'b1);
         check1("halt req", imem_req, 1'b0);
         check1("halt valid", valid_insn, 1'b0);
      end
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1);
      check1("post-halt valid", valid_insn, 1'b1);
      check32("post-halt pc", pc, RST_PC);
`else
      do_reset();
      step(0, 0, 32'h0, 1, 1);
      step(0, 1, 32'h0040_0102, 1, 1);
      check32("align addr", imem_addr, 32'h0040_0100);
      check1("align err", fetch_err, 1'b0);
      first_valid_pc("align first pc", 32'h0040_0100);
`endif

      // Randomized traffic against the model.
      do_reset();
      step(0, 0, 32'h0, 1, 0);
      for (int i = 0; i < 1500; i++) begin
         st = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 19) == 0);
         gn = ($urandom_range(0, 9) < 7);
         rv = (mem_q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0)
            rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
         else
            rpc = RST_PC + 32'($urandom_range(0, 1023)) * 4;
`ifndef FETCH_ALIGN_CHECK_EN
         rpc[1:0] = 2'($urandom_range(0, 3));
`endif
         step(st, rd, rpc, gn, rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
